// File: rtl/fp_add_special_case_stage.sv
// fp_add_special_case_stage: one-cycle IEEE-754 add/sub special-operand resolver with sticky flags and result counter
module fp_add_special_case_stage #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int CNT_WIDTH = 16,
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] float_num1,
  input  logic [DATA_WIDTH-1:0] float_num2,
  input  logic                  op_sub,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  sel,
  output logic                  flag_invalid,
  output logic                  flag_inf,
  input  logic                  flag_clr,
  output logic [CNT_WIDTH-1:0]  special_count
);
  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH-1:0] a, b, res;
  logic a_ones, b_ones, a_mnz, b_mnz, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic any_nan, opp_inf, sel_n, inv_ev, inf_ev, xfer;
  // B is sign-flipped for subtraction before it is classified
  assign a = float_num1;
  assign b = {float_num2[DATA_WIDTH-1] ^ op_sub, float_num2[DATA_WIDTH-2:0]};
  assign a_ones = &a[DATA_WIDTH-2:MAN_WIDTH];
  assign b_ones = &b[DATA_WIDTH-2:MAN_WIDTH];
  assign a_mnz = |a[MAN_WIDTH-1:0];
  assign b_mnz = |b[MAN_WIDTH-1:0];
  assign a_nan = a_ones & a_mnz;
  assign b_nan = b_ones & b_mnz;
  assign a_snan = a_nan & ~a[MAN_WIDTH-1];
  assign b_snan = b_nan & ~b[MAN_WIDTH-1];
  assign a_inf = a_ones & ~a_mnz;
  assign b_inf = b_ones & ~b_mnz;
  assign a_zero = ~|a[DATA_WIDTH-2:0];
  assign b_zero = ~|b[DATA_WIDTH-2:0];
  assign any_nan = a_nan | b_nan;
  assign opp_inf = a_inf & b_inf & (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
  always_comb begin
    res = (any_nan | opp_inf) ? QNAN :
          a_inf ? a :
          b_inf ? b :
          (a_zero & b_zero) ? {a[DATA_WIDTH-1] & b[DATA_WIDTH-1], {(DATA_WIDTH-1){1'b0}}} :
          a_zero ? b :
          b_zero ? a : '0;
    sel_n = ~(any_nan | a_inf | b_inf | a_zero | b_zero);
    inv_ev = a_snan | b_snan | opp_inf;
    inf_ev = ~any_nan & ~opp_inf & (a_inf | b_inf);
  end
  assign in_ready = ~rst & (~out_valid | out_ready);
  assign xfer = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      sel <= 1'b0;
      out_valid <= 1'b0;
      flag_invalid <= 1'b0;
      flag_inf <= 1'b0;
      special_count <= '0;
    end else begin
      if (xfer) begin
        out <= res;
        sel <= sel_n;
      end
      out_valid <= xfer | (out_valid & ~out_ready);
      flag_invalid <= (flag_invalid & ~flag_clr) | (xfer & inv_ev);
      flag_inf <= (flag_inf & ~flag_clr) | (xfer & inf_ev);
      if (xfer & ~sel_n & ~&special_count) special_count <= special_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_fp_add_special_case_stage.sv
// tb_fp_add_special_case_stage: directed vector table plus stall, saturation and reset sequences
module tb_fp_add_special_case_stage;
  logic clk = 0, rst = 1;
  logic [31:0] a = 0, b = 0;
  logic op_sub = 0, in_valid = 0, out_ready = 1, flag_clr = 0;
  logic in_ready, out_valid, sel, flag_invalid, flag_inf;
  logic [31:0] out;
  logic [15:0] special_count;
  logic in_ready2, out_valid2, sel2, flag_invalid2, flag_inf2;
  logic [31:0] out2;
  logic [1:0] special_count2;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  fp_add_special_case_stage u_dut (
    .clk(clk), .rst(rst), .float_num1(a), .float_num2(b), .op_sub(op_sub),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .sel(sel), .flag_invalid(flag_invalid), .flag_inf(flag_inf),
    .flag_clr(flag_clr), .special_count(special_count)
  );
  fp_add_special_case_stage #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .float_num1(a), .float_num2(b), .op_sub(op_sub),
    .in_valid(in_valid), .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out(out2), .sel(sel2), .flag_invalid(flag_invalid2), .flag_inf(flag_inf2),
    .flag_clr(flag_clr), .special_count(special_count2)
  );
  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [31:0] o;
    logic        s, inv, inf;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " out_valid"}, {31'b0, out_valid}, 0);
    chk({nm, " out"}, out, 0);
    chk({nm, " sel"}, {31'b0, sel}, 0);
    chk({nm, " flag_invalid"}, {31'b0, flag_invalid}, 0);
    chk({nm, " flag_inf"}, {31'b0, flag_inf}, 0);
    chk({nm, " count"}, {16'b0, special_count}, 0);
  endtask
  initial begin
    logic [15:0] cnt;
    tbl[0]  = '{32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 0, 1, 0};
    tbl[1]  = '{32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 0, 1, 0};
    tbl[2]  = '{32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 0, 1, 0};
    tbl[3]  = '{32'h80000000, 32'h80000000, 0, 32'h80000000, 0, 0, 0};
    tbl[4]  = '{32'h00000000, 32'h3F800000, 1, 32'hBF800000, 0, 0, 0};
    tbl[5]  = '{32'h3F800000, 32'h40000000, 0, 32'h00000000, 1, 0, 0};
    tbl[6]  = '{32'h7FC00000, 32'h3F800000, 0, 32'h7FC00000, 0, 0, 0};
    tbl[7]  = '{32'h3F800000, 32'hFF800000, 0, 32'hFF800000, 0, 0, 1};
    tbl[8]  = '{32'h7F800000, 32'h7F800000, 0, 32'h7F800000, 0, 0, 1};
    tbl[9]  = '{32'h00000000, 32'h80000000, 0, 32'h00000000, 0, 0, 0};
    tbl[10] = '{32'h00000000, 32'h00000000, 1, 32'h00000000, 0, 0, 0};
    tbl[11] = '{32'h80000000, 32'h00000000, 1, 32'h80000000, 0, 0, 0};
    tbl[12] = '{32'h40490FDB, 32'h00000000, 0, 32'h40490FDB, 0, 0, 0};
    tbl[13] = '{32'h00000001, 32'h3F800000, 0, 32'h00000000, 1, 0, 0};
    tbl[14] = '{32'h3F800000, 32'h7F800001, 0, 32'h7FC00000, 0, 1, 0};
    tbl[15] = '{32'hFF800000, 32'hFF800000, 1, 32'h7FC00000, 0, 1, 0};
    @(negedge clk);
    cyc();
    chk("reset in_ready", {31'b0, in_ready}, 0);
    chk_zero("reset");
    rst = 0;
    #1 chk("post-reset in_ready", {31'b0, in_ready}, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      a = tbl[i].a; b = tbl[i].b; op_sub = tbl[i].op;
      in_valid = 1; flag_clr = 1; out_ready = 1;
      cyc();
      if (!tbl[i].s) cnt++;
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 1);
      chk($sformatf("v%0d out", i), out, tbl[i].o);
      chk($sformatf("v%0d sel", i), {31'b0, sel}, {31'b0, tbl[i].s});
      chk($sformatf("v%0d invalid", i), {31'b0, flag_invalid}, {31'b0, tbl[i].inv});
      chk($sformatf("v%0d inf", i), {31'b0, flag_inf}, {31'b0, tbl[i].inf});
      chk($sformatf("v%0d count", i), {16'b0, special_count}, {16'b0, cnt});
    end
    in_valid = 0; flag_clr = 1;
    cyc();
    flag_clr = 0;
    chk("drain out_valid", {31'b0, out_valid}, 0);
    chk("clear flag_invalid", {31'b0, flag_invalid}, 0);
    a = 32'h7F800000; b = 32'h3F800000; op_sub = 0; in_valid = 1; out_ready = 0;
    cyc();
    cnt++;
    a = 32'h3F800000; b = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d out_valid", i), {31'b0, out_valid}, 1);
      chk($sformatf("stall%0d out", i), out, 32'h7F800000);
      chk($sformatf("stall%0d sel", i), {31'b0, sel}, 0);
      chk($sformatf("stall%0d in_ready", i), {31'b0, in_ready}, 0);
      chk($sformatf("stall%0d flag_inf", i), {31'b0, flag_inf}, 1);
      chk($sformatf("stall%0d count", i), {16'b0, special_count}, {16'b0, cnt});
      cyc();
    end
    in_valid = 0; out_ready = 1;
    cyc();
    chk("release out_valid", {31'b0, out_valid}, 0);
    cyc();
    chk("release idle out_valid", {31'b0, out_valid}, 0);
    chk("release count", {16'b0, special_count}, {16'b0, cnt});
    rst = 1;
    cyc();
    rst = 0;
    a = 32'h7F800000; b = 32'h3F800000; op_sub = 0; in_valid = 1; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      flag_clr = (i == 4);
      cyc();
      chk($sformatf("sat%0d count", i), {30'b0, special_count2}, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat%0d out_valid", i), {31'b0, out_valid2}, 1);
    end
    chk("clr+event flag_inf", {31'b0, flag_inf}, 1);
    chk("clr+event flag_inf w2", {31'b0, flag_inf2}, 1);
    in_valid = 0; flag_clr = 1;
    cyc();
    flag_clr = 0;
    chk("clr flag_inf", {31'b0, flag_inf}, 0);
    a = 32'hFF800000; b = 32'h7F800000; in_valid = 1; out_ready = 0;
    cyc();
    in_valid = 0;
    chk("pre-rst out_valid", {31'b0, out_valid}, 1);
    chk("pre-rst flag_invalid", {31'b0, flag_invalid}, 1);
    rst = 1;
    #1 chk("rst in_ready", {31'b0, in_ready}, 0);
    cyc();
    chk_zero("mid rst");
    rst = 0;
    out_ready = 1;
    #1 chk("after rst in_ready", {31'b0, in_ready}, 1);
    cyc();
    chk("after rst out_valid", {31'b0, out_valid}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
